// File: rtl/core_out_uart_tx.sv
// Generic FIFO with combinational head. One cycle from push to head. Pop on empty is ignored.
// Push while full is dropped unless a pop happens on the same edge.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push_vld,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop_rdy,
   output logic [WIDTH-1:0]       head_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop_rdy && (count != '0);
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign do_push  = push_vld && (!full || do_pop);
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// Queues every change of core_out and sends each queued byte as an 8N1 UART frame.
// One cycle from captured change to start bit; values arriving at a full queue are dropped and flagged.
module core_out_uart_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  core_out,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);
   localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] timer;
   logic [15:0] timer_nxt;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_idx_nxt;
   logic [7:0]  shift;
   logic [7:0]  shift_nxt;
   logic        tx_nxt;
   logic [7:0]  prev_q;
   logic        push_vld;
   logic        pop_rdy;
   logic        fifo_full;
   logic [7:0]  head_dat;

   assign push_vld = (core_out != prev_q);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q   <= 8'h00;
         overflow <= 1'b0;
      end else begin
         prev_q <= core_out;
         if (push_vld && fifo_full && !pop_rdy) begin
            overflow <= 1'b1;
         end
      end
   end

   uart_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (push_vld),
      .push_dat (core_out),
      .pop_rdy  (pop_rdy),
      .head_dat (head_dat),
      .count    (fifo_count),
      .full     (fifo_full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         timer   <= timer_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
         tx      <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      tx_nxt      = tx;
      pop_rdy     = 1'b0;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (fifo_count != '0) begin
               pop_rdy     = 1'b1;
               shift_nxt   = head_dat;
               tx_nxt      = 1'b0;
               timer_nxt   = BIT_RELOAD;
               bit_idx_nxt = '0;
               state_nxt   = START;
            end
         end
         START: begin
            if (timer == '0) begin
               state_nxt   = DATA;
               tx_nxt      = shift[0];
               timer_nxt   = BIT_RELOAD;
               bit_idx_nxt = '0;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         DATA: begin
            if (timer == '0) begin
               timer_nxt = BIT_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  // The next bit is already sitting in shift[1].
                  bit_idx_nxt = bit_idx + 1'b1;
                  shift_nxt   = {1'b0, shift[7:1]};
                  tx_nxt      = shift[1];
               end
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         STOP: begin
            if (timer == '0) begin
               state_nxt = IDLE;
               tx_nxt    = 1'b1;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_core_out_uart_tx.sv
// Directed bench for core_out_uart_tx: cycle-exact frame table plus queue, overflow and reset sequences.
module tb_core_out_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] core_out;
   logic       tx;
   logic       busy;
   logic [3:0] fifo_count;
   logic       overflow;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [7:0] rx_q[$];
   int         gap_q[$];
   int         peak = 0;

   typedef struct {
      logic [7:0] val;
      logic [9:0] line;   // start bit in [9], data LSB first, stop bit in [0]
   } vec_t;

   vec_t tbl[7];

   core_out_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_out   (core_out),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Line decoder: samples mid-bit, records bytes and idle cycles before each start bit.
   initial begin
      int         off;
      int         idle_run;
      bit         act;
      logic [7:0] b;
      off = 0; idle_run = 0; act = 0; b = '0;
      forever begin
         @(posedge clk); #1;
         if (fifo_count > peak) peak = fifo_count;
         if (reset) begin
            act = 0;
            idle_run = 0;
         end else if (!act) begin
            if (tx === 1'b0) begin
               act = 1;
               off = 0;
               gap_q.push_back(idle_run);
            end else begin
               idle_run++;
            end
         end else begin
            off++;
            if ((off % CPB) == CPB / 2 && off / CPB >= 1 && off / CPB <= 8) b[off / CPB - 1] = tx;
            if (off == 9 * CPB + CPB / 2) chk("stop bit", tx, 1'b1);
            if (off == 10 * CPB - 1) begin
               rx_q.push_back(b);
               act = 0;
               idle_run = 0;
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
      $fatal(1);
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy || fifo_count != 0) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 2000) chk("wait idle timeout", 1, 0);
   endtask

   task automatic wait_frames(input int n, input int limit);
      int k = 0;
      while (!(rx_q.size() >= n && !busy && fifo_count == 0) && k < limit) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic send_check(input logic [7:0] val, input logic [9:0] line, input string name);
      logic [63:0] wave, wexp, bwave, bexp;
      wait_idle();
      wave = '0; wexp = '0; bwave = '0; bexp = '0;
      for (int i = 0; i < 10; i++)
         for (int c = 0; c < CPB; c++) wexp[i * CPB + c] = line[9 - i];
      for (int k = 0; k < 10 * CPB; k++) bexp[k] = 1'b1;
      @(negedge clk); core_out = val;
      @(posedge clk);
      for (int k = 0; k < 10 * CPB; k++) begin
         @(posedge clk); #1;
         wave[k]  = tx;
         bwave[k] = busy;
      end
      chk({name, " tx"}, wave, wexp);
      chk({name, " busy"}, bwave, bexp);
      @(posedge clk); #1;
      chk({name, " idle after"}, {62'b0, tx, busy}, 64'h2);
   endtask

   initial begin
      int bad;
      tbl[0] = '{8'hA5, 10'b0101001011};
      tbl[1] = '{8'hFF, 10'b0111111111};
      tbl[2] = '{8'h80, 10'b0000000011};
      tbl[3] = '{8'h01, 10'b0100000001};
      tbl[4] = '{8'h5A, 10'b0010110101};
      tbl[5] = '{8'h00, 10'b0000000001};
      tbl[6] = '{8'h37, 10'b0111011001};

      reset = 1'b1;
      core_out = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset state tx/busy/count/ovf", {tx, busy, fifo_count, overflow}, 7'b1000000);
      @(negedge clk); reset = 1'b0;

      // 0x00 right after reset matches prev_q and must not start a frame.
      bad = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 4'd0) bad++;
      end
      chk("zero after reset not captured (bad cycles)", bad, 0);

      for (int i = 0; i < 7; i++)
         send_check(tbl[i].val, tbl[i].line, $sformatf("vec%0d %02h", i, tbl[i].val));

      // 0x37 stays on the bus: no further frames.
      bad = 0;
      repeat (160) begin
         @(posedge clk); #1;
         if (busy !== 1'b0 || tx !== 1'b1) bad++;
      end
      chk("held value sends once (bad cycles)", bad, 0);

      // Three changes on consecutive cycles.
      rx_q.delete(); gap_q.delete(); peak = 0;
      @(negedge clk); core_out = 8'h01;
      @(negedge clk); core_out = 8'h02;
      @(negedge clk); core_out = 8'h03;
      wait_frames(3, 300);
      chk("burst3 frame count", rx_q.size(), 3);
      chk("burst3 frame0", rx_q[0], 8'h01);
      chk("burst3 frame1", rx_q[1], 8'h02);
      chk("burst3 frame2", rx_q[2], 8'h03);
      chk("burst3 gap1", gap_q[1], 1);
      chk("burst3 gap2", gap_q[2], 1);
      chk("burst3 peak count", peak, 2);

      // Twelve changes into an 8-deep queue.
      rx_q.delete(); gap_q.delete(); peak = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); core_out = 8'h10 + 8'(i);
      end
      wait_frames(9, 800);
      repeat (60) @(posedge clk);
      #1;
      chk("overflow frame count", rx_q.size(), 9);
      for (int i = 0; i < 9; i++) chk($sformatf("overflow frame%0d", i), rx_q[i], 8'h10 + 8'(i));
      for (int i = 1; i < 9; i++) chk($sformatf("overflow gap%0d", i), gap_q[i], 1);
      chk("overflow peak count", peak, 8);
      chk("overflow flag sticky", overflow, 1'b1);

      // Reset in the middle of data bit 3, with a second value queued.
      @(negedge clk); core_out = 8'h55;
      @(negedge clk); core_out = 8'h66;
      repeat (18) @(posedge clk);
      #1;
      chk("mid-frame data bit3 of 55", {tx, busy, fifo_count}, {1'b0, 1'b1, 4'd1});
      @(negedge clk); reset = 1'b1; core_out = 8'h77;
      @(posedge clk); #1;
      chk("reset abort tx/busy/count/ovf", {tx, busy, fifo_count, overflow}, 7'b1000000);
      @(negedge clk); core_out = 8'h00;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk("change during reset ignored", {tx, busy, fifo_count}, {1'b1, 1'b0, 4'd0});
      send_check(8'h3C, 10'b0001111001, "post-reset 3C");

      // 0x00 -> 0x05 -> 0x05 -> 0x00 after reset.
      @(negedge clk); reset = 1'b1; core_out = 8'h00;
      @(negedge clk); reset = 1'b0;
      rx_q.delete(); gap_q.delete();
      @(negedge clk); core_out = 8'h05;
      @(negedge clk); core_out = 8'h05;
      @(negedge clk); core_out = 8'h00;
      wait_frames(2, 300);
      repeat (60) @(posedge clk);
      #1;
      chk("repeat seq frame count", rx_q.size(), 2);
      chk("repeat seq frame0", rx_q[0], 8'h05);
      chk("repeat seq frame1", rx_q[1], 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule

// File: doc/core_out_uart_tx.md
CORE_OUT_UART_TX -- requirements
Module: core_out_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, entries in the capture FIFO; power of two, 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 core_out  input  8  8-bit result bus driven by the core; sampled every cycle.
REQ-006 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-007 busy  output  1  high while a frame is being sent (any state other than IDLE).
REQ-008 fifo_count  output  log2(FIFO_DEPTH)+1  entries currently queued.
REQ-009 overflow  output  1  sticky flag; a captured value was dropped because the FIFO was full.

Function
REQ-010 Change detect: register prev_q holds the last sampled core_out; at each edge, if core_out != prev_q the sampled value shall be pushed to the FIFO and prev_q updated.
REQ-011 prev_q resets to 0x00, so the first nonzero core_out after reset is captured; a 0x00 after reset is not.
REQ-012 The FIFO shall be first-in first-out; a value pushed at edge E is poppable at edge E+1.
REQ-013 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; if fifo_count>0 at an edge, pop head into an 8-bit shift register, drive tx=0, go to START.
REQ-015 START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx = shift[0].
REQ-016 DATA: each bit is held CLKS_PER_BIT cycles; 8 bits, LSB first; after bit 7, go to STOP with tx=1.
REQ-017 STOP: hold tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-018 Latency: a change sampled at edge E drives tx low at edge E+1 when the FSM is IDLE and the FIFO is empty.
REQ-019 A frame occupies exactly 10*CLKS_PER_BIT cycles from tx falling to IDLE entry.
REQ-020 Back-to-back frames are separated by exactly one IDLE cycle with tx=1.
REQ-021 The bit timer shall be a down-counter reloaded with CLKS_PER_BIT-1 on each bit boundary; the bit index is 3 bits wide and does not wrap beyond 7.
REQ-022 Push and pop at the same edge: both occur and fifo_count is unchanged, including when the FIFO is full.
REQ-023 Push while full without a simultaneous pop: the value is dropped, FIFO contents are unchanged, overflow is set to 1; prev_q still updates.
REQ-024 overflow is cleared only by reset.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH and never underflows.
REQ-026 busy = (state != IDLE), registered and consistent with state in the same cycle.

Reset
REQ-027 While reset=1 at an edge: state=IDLE, tx=1, busy=0, fifo_count=0, overflow=0, prev_q=0x00, timer and bit index cleared.
REQ-028 Reset asserted mid-frame aborts the frame; tx=1 from the next edge; queued entries are discarded.
REQ-029 core_out changes while reset=1 are not captured.

Verification
REQ-030 CLKS_PER_BIT=4, core_out 0x00->0xA5 once: tx low 1 cycle later; 4-cycle bits 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop); 40 cycles; busy high for 40 cycles.
REQ-031 core_out held constant at 0x37 for 200 cycles after the first capture: exactly one frame (0x37), then tx=1 and busy=0 for the remaining cycles.
REQ-032 core_out 0x01,0x02,0x03 on consecutive cycles: three frames in order 0x01,0x02,0x03; one idle cycle between frames; fifo_count peaks at 2.
REQ-033 FIFO_DEPTH=8, 12 distinct values on consecutive cycles: the first value pops immediately, the next 8 are queued, the last 3 are dropped; overflow=1; exactly 9 frames are sent in order.
REQ-034 Reset pulse during DATA bit 3 of a frame: tx=1, busy=0, fifo_count=0, overflow=0 after the reset edge; the next change after reset transmits normally.
REQ-035 Sequence 0x00->0x05->0x05->0x00 after reset: frames 0x05 then 0x00; the repeated 0x05 is not sent.
